ctrl_sequencer: RTL
===================

Name: ctrl_sequencer

Overview:
Multi-cycle control sequencer for the 9-bit-instruction core. It owns the program counter, steps fetch/decode/execute, and drives the enables for the ALU carry, reg_file, data_mem and lookup.
Sits between fetch/instruction ROM and the datapath. Performs data_mem accesses with a req/ack handshake and a timeout. Produces the core's done (halt) signal.

Parameters:
PC_W, 10, program counter width (ROM depth 2^PC_W)
MEM_TIMEOUT, 15, max cycles waiting for mem_ack_i before error halt (1..255)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  level; begins/restarts execution from PC 0
inst_i  input  9  instruction word from ROM at pc_o
pc_target_i  input  PC_W  branch target from lookup, indexed by ir[5:0]
alu_zero_i  input  1  ALU zero flag
mem_ack_i  input  1  data_mem access complete
pc_o  output  PC_W  current program counter
ir_o  output  9  latched instruction register
reg_we_o  output  1  reg_file write enable
wb_sel_o  output  2  writeback source: 00 ALU, 01 lookup, 10 data_mem
carry_en_o  output  1  ALU carry/overflow register enable
mem_req_o  output  1  data_mem request
mem_we_o  output  1  data_mem write (valid with mem_req_o)
done_o  output  1  halted
err_o  output  1  memory timeout occurred
retired_o  output  16  retired instruction count

Behaviour:
- Opcode = ir[8:6]:
  - 000 ALU
  - 001 LDI (lookup value to reg)
  - 010 LD
  - 011 ST
  - 100 BZ
  - 101 BR
  - 110 NOP
  - 111 HALT
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE.
- Reset asserted, at any time including mid-access:
  - state = IDLE; pc, ir, retired, timeout counter = 0.
  - All outputs 0. mem_req_o drops immediately, without waiting for a clock edge.
- IDLE: go to FETCH when start=1.
- FETCH, 1 cycle: ir <= inst_i at the end of the cycle.
- DECODE, 1 cycle: no enables asserted.
- EXEC, 1 cycle:
  - ALU: reg_we_o=1, wb_sel_o=00, carry_en_o=1; pc <= pc+1; then FETCH.
  - LDI: reg_we_o=1, wb_sel_o=01; pc <= pc+1; then FETCH.
  - LD/ST: go to MEM.
  - BZ: pc <= alu_zero_i ? pc_target_i : pc+1 (alu_zero_i sampled in EXEC); then FETCH.
  - BR: pc <= pc_target_i; then FETCH.
  - NOP: pc <= pc+1; then FETCH.
  - HALT: pc unchanged; go to DONE.
- MEM:
  - mem_req_o=1, held continuously; mem_we_o = (opcode==ST).
  - mem_ack_i is sampled only in MEM.
  - Ack received: ST does pc <= pc+1 and goes to FETCH; LD goes to WB.
  - Ack asserted in the first MEM cycle is legal (zero-wait access).
  - Timeout counter counts MEM cycles without ack. If MEM_TIMEOUT cycles pass with no ack: err_o=1, mem_req_o drops, go to DONE.
- WB, 1 cycle: reg_we_o=1, wb_sel_o=10; pc <= pc+1; then FETCH.
- mem_ack_i outside MEM: ignored.
- DONE:
  - done_o=1 and err_o held.
  - start=1 clears done_o, err_o, pc and retired, then goes to FETCH.
  - start ignored in every state except IDLE and DONE.
- Cycles per instruction:
  - 3: ALU, LDI, NOP, branches.
  - 4+wait: ST.
  - 5+wait: LD, where wait = extra MEM cycles before ack.
- pc+1 wraps from 2^PC_W-1 to 0.
- retired_o:
  - Increments on each instruction completion, including HALT.
  - Does not increment on a timed-out access.
  - Saturates at 16'hFFFF.
- reg_we_o, carry_en_o, mem_req_o are all 0 in IDLE, FETCH, DECODE and DONE.
- Outputs are registered or decoded from state only. No combinational path from inst_i to any output.

Test Plan:
1. Reset low, start=1, then release → FETCH with pc_o=0. ROM: ALU, LDI, NOP, HALT → reg_we_o pulses in EXEC with wb_sel 00 then 01; done_o=1 on cycle 12; retired_o=4; pc_o=3.
2. LD at pc 0, ack after 3 MEM cycles → mem_req_o high exactly 3 cycles, mem_we_o=0; WB pulse with wb_sel_o=10; pc_o=1. Repeat as ST → mem_we_o=1, no WB.
3. BZ with pc_target_i=0x2A:
   - alu_zero_i=1 → pc_o=0x2A.
   - alu_zero_i=0 → pc_o=pc+1.
   - BR at pc 0x3FF with target 5 → pc_o=5. NOP at 0x3FF → pc_o wraps to 0.
4. LD with mem_ack_i never asserted, MEM_TIMEOUT=15 → mem_req_o high 15 cycles, then err_o=1, done_o=1, retired_o unchanged. Then start=1 → err_o=0, pc_o=0.
5. Reset asserted mid-MEM, off clock edge → mem_req_o=0 and pc_o=0 immediately. Stray mem_ack_i pulses in FETCH/DECODE → no state change.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/decode/execute sequencer for the 9-bit core.
// Owns the PC, drives datapath enables, and runs data_mem req/ack with a timeout.
module ctrl_sequencer #(
    parameter int PC_W        = 10,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [8:0]      inst_i,
    input  logic [PC_W-1:0] pc_target_i,
    input  logic            alu_zero_i,
    input  logic            mem_ack_i,
    output logic [PC_W-1:0] pc_o,
    output logic [8:0]      ir_o,
    output logic            reg_we_o,
    output logic [1:0]      wb_sel_o,
    output logic            carry_en_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic            done_o,
    output logic            err_o,
    output logic [15:0]     retired_o
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE} state_t;
    localparam logic [2:0] OP_ALU = 3'd0, OP_LDI = 3'd1, OP_LD = 3'd2, OP_ST = 3'd3,
                           OP_BZ  = 3'd4, OP_BR  = 3'd5, OP_NOP = 3'd6;
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic [8:0]      ir_q, ir_d;
    logic [15:0]     ret_q, ret_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            err_q, err_d, retire, clr;
    logic [2:0]      op;

    assign op     = ir_q[8:6];
    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        retire     = 1'b0;
        clr        = 1'b0;
        reg_we_o   = 1'b0;
        wb_sel_o   = 2'b00;
        carry_en_o = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = FETCH;
            FETCH:  begin
                ir_d    = inst_i;
                state_d = DECODE;
            end
            DECODE: state_d = EXEC;
            EXEC:   begin
                state_d = FETCH;
                retire  = 1'b1;
                tmo_d   = '0;
                case (op)
                    OP_ALU: begin
                        reg_we_o   = 1'b1;
                        carry_en_o = 1'b1;
                        pc_d       = pc_inc;
                    end
                    OP_LDI: begin
                        reg_we_o = 1'b1;
                        wb_sel_o = 2'b01;
                        pc_d     = pc_inc;
                    end
                    OP_LD, OP_ST: begin
                        state_d = MEM;
                        retire  = 1'b0;
                    end
                    OP_BZ:  pc_d = alu_zero_i ? pc_target_i : pc_inc;
                    OP_BR:  pc_d = pc_target_i;
                    OP_NOP: pc_d = pc_inc;
                    default: state_d = DONE;
                endcase
            end
            MEM:    begin
                mem_req_o = 1'b1;
                mem_we_o  = (op == OP_ST);
                if (mem_ack_i) begin
                    state_d = (op == OP_ST) ? FETCH : WB;
                    retire  = (op == OP_ST);
                    pc_d    = (op == OP_ST) ? pc_inc : pc_q;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            WB:     begin
                reg_we_o = 1'b1;
                wb_sel_o = 2'b10;
                pc_d     = pc_inc;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            DONE:   if (start) begin
                clr     = 1'b1;
                pc_d    = '0;
                err_d   = 1'b0;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        ret_d = clr ? 16'd0 : (retire && ret_q != 16'hFFFF) ? ret_q + 16'd1 : ret_q;
    end

    // mem_req_o decodes state_q, so the async reset drops it without a clock edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            ret_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ret_q   <= ret_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign pc_o      = pc_q;
    assign ir_o      = ir_q;
    assign done_o    = (state_q == DONE);
    assign err_o     = err_q;
    assign retired_o = ret_q;
endmodule
